rpn_operand_stack: RTL and testbench
====================================

Name: rpn_operand_stack

Overview:
Parametrised RPN operand stack for the ALU datapath. It generalises the earlier single-flag "reuse previous result" memory into a DEPTH-entry, WIDTH-bit LIFO. The block accepts PUSH/POP/BINOP/CLEAR commands, presents the top two entries to the ALU, and waits on an ALU handshake. It then writes the ALU result back in place of the two operands, so chained RPN expressions evaluate without re-entering values from the switches.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, number of stack entries (>=2)
CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridden)

Ports:
CLOCK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_code  input  2  00 PUSH, 01 POP, 10 BINOP, 11 CLEAR
push_data  input  WIDTH  operand for PUSH
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
alu_req  output  1  operands valid, ALU must compute
alu_a  output  WIDTH  second-from-top (NOS), left operand
alu_b  output  WIDTH  top (TOS), right operand
alu_done  input  1  one-cycle pulse, alu_result valid
alu_result  input  WIDTH  ALU output
tos  output  WIDTH  current top of stack, 0 when empty
depth  output  CNT_W  number of occupied entries
empty  output  1  depth==0
full  output  1  depth==DEPTH
result_on_top  output  1  TOS is an ALU result (successor of the manual/result mux select)
overflow  output  1  sticky: PUSH attempted while full
underflow  output  1  sticky: POP on empty, or BINOP with depth<2

Behaviour:
- Reset (synchronous, RESET=1 at edge): depth=0, state IDLE, alu_req=0, cmd_ready=1, result_on_top=0, overflow=0, underflow=0. Entry contents are unreset, but tos/alu_a/alu_b are masked to 0 when the entry is not occupied.
- FSM states: IDLE and WAIT_ALU. cmd_ready = (state==IDLE). alu_req = (state==WAIT_ALU). Commands presented while cmd_ready=0 are not accepted and not queued.
- PUSH, depth<DEPTH: mem[depth]<=push_data; depth+1; result_on_top<=0. All updates are visible in the next cycle.
- PUSH, full: no change; overflow<=1.
- POP, depth>0: depth-1; result_on_top<=0.
- POP, empty: no change; underflow<=1.
- BINOP, depth>=2: go to WAIT_ALU. alu_a=mem[depth-2] and alu_b=mem[depth-1] are held stable for the whole wait.
- BINOP, depth<2: stay IDLE; underflow<=1; no alu_req.
- In WAIT_ALU, on alu_done: mem[depth-2]<=alu_result; depth-1; result_on_top<=1; return to IDLE. cmd_ready returns to 1 on the following cycle. Minimum BINOP latency is 2 cycles (accept edge, then done edge).
- The wait has no timeout. alu_done in IDLE is ignored.
- CLEAR: depth<=0; result_on_top<=0; overflow<=0; underflow<=0. Entry contents are left as-is. CLEAR is accepted only in IDLE.
- RESET during WAIT_ALU aborts the operation to IDLE with depth 0. An alu_done arriving later is ignored.
- RESET has priority over any command or alu_done in the same cycle.
- Sticky flags clear only on CLEAR or RESET. A successful command does not clear them.
- A BINOP result on a full stack is legal. Depth goes DEPTH -> DEPTH-1, so full deasserts.
- Depth arithmetic never wraps; the guards above make 0-1 and DEPTH+1 unreachable.

Decomposition:
- Shared package rpn_pkg holds the cmd_code encodings (CMD_PUSH, CMD_POP, CMD_BINOP, CMD_CLEAR) and the state encoding (ST_IDLE, ST_WAIT_ALU).
- One natural sub-module, rpn_stack_mem: a DEPTH x WIDTH register file with one write port and two combinational read ports (TOS, NOS) plus occupancy masking.
- Control FSM and flags live in the top module.

Test Plan:
1. RESET, then PUSH 0x05, PUSH 0x03 -> depth=2, tos=0x03, alu_a=0x05, alu_b=0x03, empty=0, result_on_top=0.
2. From (1): BINOP, ALU answers alu_done with 0x08 three cycles later -> cmd_ready=0 and alu_req=1 held throughout. Then depth=1, tos=0x08, result_on_top=1, cmd_ready=1 next cycle.
3. PUSH 0x11,0x22,0x33,0x44, then PUSH 0x55 (DEPTH=4) -> full=1, overflow=1, tos=0x44, depth=4. BINOP with result 0x77 -> depth=3, tos=0x77, full=0, overflow still 1.
4. After RESET: POP -> underflow=1, depth=0. PUSH 0x09 then BINOP -> underflow stays 1, alu_req never asserts, depth=1. CLEAR -> underflow=0, overflow=0, depth=0.
5. PUSH 0x02, PUSH 0x04, BINOP, RESET asserted while alu_req=1, then alu_done pulsed with 0xFF -> depth=0, tos=0, alu_req=0, result_on_top=0.
6. alu_done pulsed with 0xAA while IDLE at depth=2 -> stack unchanged. cmd_valid held with PUSH during WAIT_ALU -> accepted only in the first cycle cmd_ready=1, pushed exactly once.

Source files
------------

// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - command and state encodings shared by the RPN operand stack
package rpn_pkg;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_BINOP = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ALU = 1'b1
    } state_e;

endpackage

// File: rtl/rpn_stack_mem.sv
// rtl/rpn_stack_mem.sv - DEPTH x WIDTH register file with TOS/NOS read ports masked by occupancy
module rpn_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [CNT_W-1:0] depth_i,
    output logic [WIDTH-1:0] tos_o,
    output logic [WIDTH-1:0] nos_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entries are deliberately left unreset; occupancy masking hides stale data.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_i && (waddr_i == CNT_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_comb begin
        tos_o = '0;
        nos_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_i == CNT_W'(i + 1)) tos_o = mem_q[i];
            if (depth_i == CNT_W'(i + 2)) nos_o = mem_q[i];
        end
    end

endmodule

// File: rtl/rpn_operand_stack.sv
// rtl/rpn_operand_stack.sv - RPN operand LIFO with ALU handshake, occupancy and sticky error flags
module rpn_operand_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_code,
    input  logic [WIDTH-1:0] push_data,
    output logic             cmd_ready,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] tos,
    output logic [CNT_W-1:0] depth,
    output logic             empty,
    output logic             full,
    output logic             result_on_top,
    output logic             overflow,
    output logic             underflow
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             rot_q, rot_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             mem_we;
    logic [CNT_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] tos_w, nos_w;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            depth_q <= '0;
            rot_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            rot_q   <= rot_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        rot_d     = rot_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_waddr = depth_q;
        mem_wdata = push_data;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        CMD_PUSH: begin
                            if (depth_q != CNT_W'(DEPTH)) begin
                                mem_we  = 1'b1;
                                depth_d = depth_q + CNT_W'(1);
                                rot_d   = 1'b0;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        CMD_POP: begin
                            if (depth_q != '0) begin
                                depth_d = depth_q - CNT_W'(1);
                                rot_d   = 1'b0;
                            end else begin
                                unf_d = 1'b1;
                            end
                        end
                        CMD_BINOP: begin
                            if (depth_q >= CNT_W'(2)) state_d = ST_WAIT_ALU;
                            else                      unf_d   = 1'b1;
                        end
                        default: begin
                            depth_d = '0;
                            rot_d   = 1'b0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_WAIT_ALU: begin
                // Result replaces NOS; dropping depth by one discards the old TOS.
                if (alu_done) begin
                    mem_we    = 1'b1;
                    mem_waddr = depth_q - CNT_W'(2);
                    mem_wdata = alu_result;
                    depth_d   = depth_q - CNT_W'(1);
                    rot_d     = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    rpn_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_mem (
        .clk_i   (CLOCK),
        .we_i    (mem_we & ~RESET),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .depth_i (depth_q),
        .tos_o   (tos_w),
        .nos_o   (nos_w)
    );

    assign cmd_ready     = (state_q == ST_IDLE);
    assign alu_req       = (state_q == ST_WAIT_ALU);
    assign alu_a         = nos_w;
    assign alu_b         = tos_w;
    assign tos           = tos_w;
    assign depth         = depth_q;
    assign empty         = (depth_q == '0);
    assign full          = (depth_q == CNT_W'(DEPTH));
    assign result_on_top = rot_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// tb/tb_rpn_operand_stack.sv - directed and randomized bench against a queue-based stack model
module tb_rpn_operand_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] PUSH  = 2'b00;
    localparam logic [1:0] POP   = 2'b01;
    localparam logic [1:0] BINOP = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic             CLOCK = 1'b0;
    logic             RESET = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_code = 2'b00;
    logic [WIDTH-1:0] push_data = '0;
    logic             cmd_ready;
    logic             alu_req;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done = 1'b0;
    logic [WIDTH-1:0] alu_result = '0;
    logic [WIDTH-1:0] tos;
    logic [CNT_W-1:0] depth;
    logic             empty;
    logic             full;
    logic             result_on_top;
    logic             overflow;
    logic             underflow;

    int total = 0;
    int bad   = 0;

    int q[$];
    bit m_wait, m_ovf, m_unf, m_rot;

    rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code),
        .push_data     (push_data),
        .cmd_ready     (cmd_ready),
        .alu_req       (alu_req),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_done      (alu_done),
        .alu_result    (alu_result),
        .tos           (tos),
        .depth         (depth),
        .empty         (empty),
        .full          (full),
        .result_on_top (result_on_top),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input bit v, input logic [1:0] code,
                         input logic [7:0] data, input bit done, input logic [7:0] res);
        if (rst) begin
            q.delete();
            m_wait = 0; m_ovf = 0; m_unf = 0; m_rot = 0;
        end else if (!m_wait) begin
            if (v) begin
                case (code)
                    PUSH:  if (q.size() < DEPTH) begin q.push_back(int'(data)); m_rot = 0; end
                           else m_ovf = 1;
                    POP:   if (q.size() > 0) begin void'(q.pop_back()); m_rot = 0; end
                           else m_unf = 1;
                    BINOP: if (q.size() >= 2) m_wait = 1;
                           else m_unf = 1;
                    default: begin q.delete(); m_rot = 0; m_ovf = 0; m_unf = 0; end
                endcase
            end
        end else if (done) begin
            void'(q.pop_back());
            void'(q.pop_back());
            q.push_back(int'(res));
            m_rot = 1;
            m_wait = 0;
        end
    endtask

    task automatic check_all();
        int n;
        int e_tos, e_nos;
        n = q.size();
        e_tos = (n >= 1) ? q[n-1] : 0;
        e_nos = (n >= 2) ? q[n-2] : 0;
        check("depth", 32'(depth), 32'(n));
        check("tos", 32'(tos), 32'(e_tos));
        check("alu_b", 32'(alu_b), 32'(e_tos));
        check("alu_a", 32'(alu_a), 32'(e_nos));
        check("cmd_ready", 32'(cmd_ready), 32'(!m_wait));
        check("alu_req", 32'(alu_req), 32'(m_wait));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("result_on_top", 32'(result_on_top), 32'(m_rot));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [1:0] code,
                       input logic [7:0] data, input bit done, input logic [7:0] res);
        RESET = rst; cmd_valid = v; cmd_code = code; push_data = data;
        alu_done = done; alu_result = res;
        model(rst, v, code, data, done, res);
        @(posedge CLOCK);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, PUSH, 8'h00, 0, 8'h00);
    endtask

    initial begin
        // 1: reset, two pushes
        cyc(1, 0, PUSH, 8'h00, 0, 8'h00);
        check("t1_reset_ready", 32'(cmd_ready), 32'd1);
        cyc(0, 1, PUSH, 8'h05, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h03, 0, 8'h00);
        check("t1_alu_a", 32'(alu_a), 32'h05);
        check("t1_alu_b", 32'(alu_b), 32'h03);

        // 2: binop, result three cycles later
        cyc(0, 1, BINOP, 8'h00, 0, 8'h00);
        idle(2);
        cyc(0, 0, PUSH, 8'h00, 1, 8'h08);
        check("t2_tos", 32'(tos), 32'h08);
        check("t2_rot", 32'(result_on_top), 32'd1);

        // 3: fill, overflow, binop on full stack
        cyc(1, 0, PUSH, 8'h00, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h11, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h22, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h33, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h44, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h55, 0, 8'h00);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_tos", 32'(tos), 32'h44);
        cyc(0, 1, BINOP, 8'h00, 0, 8'h00);
        cyc(0, 0, PUSH, 8'h00, 1, 8'h77);
        check("t3_depth", 32'(depth), 32'd3);
        check("t3_tos77", 32'(tos), 32'h77);

        // 4: underflow paths and clear
        cyc(1, 0, PUSH, 8'h00, 0, 8'h00);
        cyc(0, 1, POP, 8'h00, 0, 8'h00);
        check("t4_underflow", 32'(underflow), 32'd1);
        cyc(0, 1, PUSH, 8'h09, 0, 8'h00);
        cyc(0, 1, BINOP, 8'h00, 0, 8'h00);
        check("t4_no_req", 32'(alu_req), 32'd0);
        cyc(0, 1, CLEAR, 8'h00, 0, 8'h00);
        check("t4_cleared", 32'(underflow), 32'd0);

        // 5: reset aborts the ALU wait; late done ignored
        cyc(0, 1, PUSH, 8'h02, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h04, 0, 8'h00);
        cyc(0, 1, BINOP, 8'h00, 0, 8'h00);
        cyc(1, 0, PUSH, 8'h00, 0, 8'h00);
        cyc(0, 0, PUSH, 8'h00, 1, 8'hFF);
        check("t5_depth", 32'(depth), 32'd0);

        // 6: stray done in IDLE; held PUSH during wait pushed exactly once
        cyc(0, 1, PUSH, 8'h12, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h34, 0, 8'h00);
        cyc(0, 0, PUSH, 8'h00, 1, 8'hAA);
        check("t6_tos", 32'(tos), 32'h34);
        cyc(0, 1, BINOP, 8'h00, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h66, 0, 8'h00);
        cyc(0, 1, PUSH, 8'h66, 1, 8'h46);
        cyc(0, 1, PUSH, 8'h66, 0, 8'h00);
        cyc(0, 0, PUSH, 8'h00, 0, 8'h00);
        check("t6_depth", 32'(depth), 32'd2);
        check("t6_nos", 32'(alu_a), 32'h46);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit rst, v, dn;
            int r;
            logic [1:0] code;
            rst = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            code = (r < 5) ? PUSH : (r < 7) ? POP : (r < 9) ? BINOP : CLEAR;
            dn = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cyc(rst, v, code, 8'($urandom), dn, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
